// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-high segment
// patterns in a..g order and counter-width helper.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_decode.sv
// BCD digit to active-high segment pattern; codes 10-15 render as a dash.
module bcd_digit_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        if (blank) begin
            pattern = SEG_OFF;
        end else begin
            case (bcd)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with frame-aligned commit of loaded
// BCD data, per-slot dead time and optional leading-zero blanking.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 16,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    update_pending,
    output logic                    frame_tick
);

    localparam int PW = cnt_width(REFRESH_DIV);
    localparam int DW = cnt_width(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_END = PW'(DEAD_CYCLES);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]           prescaler;
    logic [DW-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0] pend_bcd, disp_bcd;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp;
    logic                    pres_tc, frame_bnd;
    logic [3:0]              cur_bcd;
    logic                    cur_dp, cur_lz;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              cur_pat;

    assign pres_tc   = (prescaler == PRE_LAST);
    assign frame_bnd = pres_tc && (digit_idx == DIG_LAST);

    // Select the scanned digit; cur_lz marks it as a leading zero when it and
    // everything above it are zero (digit 0 always stays visible).
    always_comb begin
        cur_bcd = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        an_next = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_next[k] = (prescaler >= DEAD_END) && (digit_idx == DW'(k));
            if (digit_idx == DW'(k)) begin
                cur_bcd = disp_bcd[4*k +: 4];
                cur_dp  = disp_dp[k];
                cur_lz  = (k != 0);
                for (int j = k; j < NUM_DIGITS; j++) begin
                    if (disp_bcd[4*j +: 4] != 4'd0) cur_lz = 1'b0;
                end
            end
        end
    end

    bcd_digit_decode u_decode (
        .bcd     (cur_bcd),
        .blank   (blank_lz && cur_lz),
        .pattern (cur_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_bnd;
            if (pres_tc) begin
                prescaler <= '0;
                digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // A load landing on the boundary bypasses pending and supersedes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_bcd       <= '0;
            pend_dp        <= '0;
            disp_bcd       <= '0;
            disp_dp        <= '0;
            update_pending <= 1'b0;
        end else if (load && frame_bnd) begin
            disp_bcd       <= bcd_in;
            disp_dp        <= dp_in;
            update_pending <= 1'b0;
        end else if (load) begin
            pend_bcd       <= bcd_in;
            pend_dp        <= dp_in;
            update_pending <= 1'b1;
        end else if (frame_bnd && update_pending) begin
            disp_bcd       <= pend_bcd;
            disp_dp        <= pend_dp;
            update_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            seg <= {7{SEG_ACTIVE_LOW}};
            dp  <= SEG_ACTIVE_LOW;
        end else begin
            an  <= AN_ACTIVE_LOW  ? ~an_next : an_next;
            seg <= SEG_ACTIVE_LOW ? ~cur_pat : cur_pat;
            dp  <= SEG_ACTIVE_LOW ? ~cur_dp  : cur_dp;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: stimulus queues expected slot
// outputs tagged with a cycle number, a negedge monitor pops and compares.
module tb_seven_seg_scanner;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SD = 7'b0000001;
    localparam logic [6:0] SB = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        update_pending;
    logic        frame_tick;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       upd;
        logic       ft;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    seven_seg_scanner #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (8),
        .DEAD_CYCLES    (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .bcd_in         (bcd_in),
        .dp_in          (dp_in),
        .blank_lz       (blank_lz),
        .seg            (seg),
        .dp             (dp),
        .an             (an),
        .update_pending (update_pending),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d an=%b (at most one low bit allowed)", cyc, an);
            end
        end
        if (sb.size() > 0) begin
            if (sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed entry for cyc=%0d (now cyc=%0d)", e.cyc, cyc);
            end else if (sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({an, seg, dp, update_pending, frame_tick} !== {e.an, e.seg, e.dp, e.upd, e.ft}) begin
                    errors++;
                    $display("FAIL slot cyc=%0d got an=%b seg=%b dp=%b upd=%b ft=%b want an=%b seg=%b dp=%b upd=%b ft=%b",
                             cyc, an, seg, dp, update_pending, frame_tick, e.an, e.seg, e.dp, e.upd, e.ft);
                end
            end
        end
    end

    task automatic push(input int n, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input logic u, input logic f);
        exp_t e;
        e.cyc = n; e.an = a; e.seg = s; e.dp = d; e.upd = u; e.ft = f;
        sb.push_back(e);
    endtask

    // segs packed {d3,d2,d1,d0}; update_pending expected high for n in [lo,hi)
    task automatic push_frame(input int k, input logic [27:0] segs, input logic [3:0] dps,
                              input int lo, input int hi, input int nmax);
        int n;
        for (int d = 0; d < 4; d++) begin
            n = 32*k + 8*d + 1;
            if (n <= nmax) push(n, 4'b1111, segs[7*d +: 7], dps[d], (n >= lo && n < hi), 1'b0);
            n = n + 4;
            if (n <= nmax) push(n, 4'b1111 ^ (4'b0001 << d), segs[7*d +: 7], dps[d], (n >= lo && n < hi), 1'b0);
        end
        n = 32*k + 32;
        if (n <= nmax) push(n, 4'b0111, segs[27:21], dps[3], (n >= lo && n < hi), 1'b1);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load is sampled at edge n+1.
    task automatic do_load(input int n, input logic [15:0] b, input logic [3:0] d);
        goto(n);
        bcd_in = b;
        dp_in  = d;
        load   = 1'b1;
        goto(n + 1);
        load   = 1'b0;
        dp_in  = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        bcd_in   = '0;
        dp_in    = '0;
        blank_lz = 1'b0;
        push(0, 4'b1111, 7'b0000000, 1'b0, 1'b0, 1'b0);
        push_frame(0, {S0, S0, S0, S0}, 4'b0000, 0,   0,   1000000);
        push_frame(1, {S0, S0, S0, S0}, 4'b0000, 41,  64,  1000000);
        push_frame(2, {S1, S2, S3, S4}, 4'b0100, 71,  96,  1000000);
        push_frame(3, {SB, SB, SB, S7}, 4'b0010, 0,   0,   1000000);
        push_frame(4, {S0, S0, S0, S7}, 4'b0010, 136, 160, 1000000);
        push_frame(5, {SD, SD, S0, S9}, 4'b0000, 166, 192, 1000000);
        push_frame(6, {S2, S2, S2, S2}, 4'b0000, 211, 224, 1000000);
        push_frame(7, {S5, S6, S7, S8}, 4'b0000, 241, 256, 244);
        #22 rst_n = 1'b1;

        do_load(40, 16'h1234, 4'b0100);
        do_load(70, 16'h0007, 4'b0010);
        goto(96);  blank_lz = 1'b1;
        goto(128); blank_lz = 1'b0;
        do_load(135, 16'hAF09, 4'b0000);
        goto(160); blank_lz = 1'b1;
        do_load(165, 16'h1111, 4'b0000);
        do_load(180, 16'h2222, 4'b0000);
        goto(192); blank_lz = 1'b0;
        do_load(210, 16'h9999, 4'b0000);
        do_load(223, 16'h5678, 4'b0000);
        do_load(240, 16'h4321, 4'b1111);

        // asynchronous reset between edges while 4321 is still pending
        goto(245);
        #2 rst_n = 1'b0;
        #1 push(0, 4'b1111, 7'b0000000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        push_frame(0, {S0, S0, S0, S0}, 4'b0000, 0, 0, 1000000);
        push_frame(1, {S0, S0, S0, S0}, 4'b0000, 0, 0, 1000000);

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
